pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Parametrised successor to the combinational next-PC adder.
- Holds the architectural fetch PC in a register and advances it by INSTR_BYTES each accepted fetch.
- Evaluates all six RV branch conditions plus JAL/JALR from Execute-stage inputs, and redirects fetch with a one-cycle flush.
- Redirects that arrive while fetch is not ready are buffered in a pending register, so none is lost. The block sits between Execute and the IF stage.

Parameters:
- ADDR_W, 8, PC/address width in bits.
- IMM_W, 64, width of the immediate from immgen; only the low ADDR_W bits are used.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_ready  in  1  IF accepts the current pc this cycle; PC may update only when high.
- ex_valid  in  1  Execute-stage control-flow inputs are valid this cycle.
- ex_branch  in  1  conditional branch.
- ex_jal  in  1  JAL.
- ex_jalr  in  1  JALR.
- ex_funct3  in  3  branch type.
- zero_flag  in  1  ALU result == 0.
- lt_flag  in  1  signed less-than.
- ltu_flag  in  1  unsigned less-than.
- ex_pc  in  ADDR_W  PC of the Execute-stage instruction.
- ex_imm  in  IMM_W  sign-extended immediate.
- ex_rs1  in  ADDR_W  rs1 value, used for JALR.
- pc  out  ADDR_W  current fetch PC (registered).
- pc_plus4  out  ADDR_W  pc + INSTR_BYTES (combinational from pc).
- flush  out  1  one-cycle pulse; IF/ID must squash their contents.
- taken  out  1  registered; redirect decided last cycle.
- misaligned  out  1  registered one-cycle pulse; computed target had bit 1 set.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=RUN, pending cleared, flush=0, taken=0, misaligned=0. Deasserting rst_n mid-operation discards any pending redirect.
- Branch condition by funct3:
  - 000 BEQ: zero_flag
  - 001 BNE: !zero_flag
  - 100 BLT: lt_flag
  - 101 BGE: !lt_flag
  - 110 BLTU: ltu_flag
  - 111 BGEU: !ltu_flag
  - 010 and 011: never taken.
- Targets, all arithmetic modulo 2^ADDR_W with silent wrap:
  - branch/JAL: ex_pc + ex_imm[ADDR_W-1:0]
  - JALR: (ex_rs1 + ex_imm[ADDR_W-1:0]) with bit 0 cleared.
- Redirect request: ex_valid & (ex_jal | ex_jalr | (ex_branch & cond)). Priority when several are set: ex_jalr > ex_jal > ex_branch.
- Misaligned: if the target has bit 1 set, suppress the redirect, pulse misaligned the next cycle, and keep PC sequential.
- State RUN:
  - Redirect & fetch_ready: pc <= target next edge; flush=1 and taken=1 for that one cycle.
  - Redirect & !fetch_ready: latch target into pending, go to HOLD. pc is unchanged and flush is not yet asserted.
  - No redirect & fetch_ready: pc <= pc + INSTR_BYTES.
  - No redirect & !fetch_ready: pc holds.
- State HOLD:
  - While !fetch_ready: pc holds.
  - A new valid redirect overwrites pending, last writer wins.
  - When fetch_ready=1: pc <= pending (or the new same-cycle redirect target, which takes precedence), flush=1 and taken=1 for one cycle, return to RUN.
- Latency: redirect to pc update is one edge when fetch_ready is high.
- flush and taken are never high for more than one consecutive cycle per redirect.

Decomposition:
- Shared package (riscv_pkg): funct3 branch encodings (F3_BEQ through F3_BGEU) and the RUN/HOLD state encoding.
- One sub-module: branch_cond_eval, combinational; inputs funct3 and flags, output cond.
- The target adder and FSM live in the top module.

Test Plan:
- Reset, then fetch_ready=1 for 3 cycles -> pc = 0x00, 0x04, 0x08, 0x0C; flush=0.
- pc at 0x20, ex_pc=0x20, imm=4, ex_branch=1, funct3=000, zero=1 -> next pc 0x24; flush=1 and taken=1 for 1 cycle. Same with zero=0 -> pc continues sequentially, flush=0.
- BLT with lt=1, BGEU with ltu=1, funct3=010 -> taken, not taken, not taken respectively.
- JALR ex_rs1=0x41, imm=0x3 -> pc 0x44. JAL ex_pc=0xFC, imm=0x8 -> wraps to 0x04. Target 0x22 -> misaligned pulse, no flush.
- fetch_ready=0 while a BEQ redirect to 0x40 fires, held 3 cycles -> pc frozen, no flush. Then fetch_ready=1 -> pc 0x40, one flush. A second redirect to 0x60 during the hold -> 0x60 wins.
- rst_n asserted while in HOLD -> pc=RESET_PC immediately (asynchronously); pending discarded, no flush after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 control-flow encodings: branch funct3 values and the redirect FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int         STATE_W = 1;
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Execute-to-fetch control-flow bundle; the redirect unit is the slave side.
interface pc_redirect_unit_if #(
    parameter int ADDR_W = 8,
    parameter int IMM_W  = 64
);
    logic              fetch_ready;
    logic              ex_valid;
    logic              ex_branch;
    logic              ex_jal;
    logic              ex_jalr;
    logic [2:0]        ex_funct3;
    logic              zero_flag;
    logic              lt_flag;
    logic              ltu_flag;
    logic [ADDR_W-1:0] ex_pc;
    logic [IMM_W-1:0]  ex_imm;
    logic [ADDR_W-1:0] ex_rs1;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              flush;
    logic              taken;
    logic              misaligned;

    modport master (
        output fetch_ready, ex_valid, ex_branch, ex_jal, ex_jalr, ex_funct3,
               zero_flag, lt_flag, ltu_flag, ex_pc, ex_imm, ex_rs1,
        input  pc, pc_plus4, flush, taken, misaligned
    );

    modport slave (
        input  fetch_ready, ex_valid, ex_branch, ex_jal, ex_jalr, ex_funct3,
               zero_flag, lt_flag, ltu_flag, ex_pc, ex_imm, ex_rs1,
        output pc, pc_plus4, flush, taken, misaligned
    );

endinterface

// File: rtl/pc_redirect_unit_cond.sv
// Combinational RV branch-condition evaluator driven by the ALU comparison flags.
module branch_cond_eval
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero_flag,
    input  logic       lt_flag,
    input  logic       ltu_flag,
    output logic       cond
);

    always_comb begin
        // NOTE: default first so every path assigns cond and no latch is inferred.
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero_flag;
            F3_BNE:  cond = !zero_flag;
            F3_BLT:  cond = lt_flag;
            F3_BGE:  cond = !lt_flag;
            F3_BLTU: cond = ltu_flag;
            F3_BGEU: cond = !ltu_flag;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect, one-cycle flush, and a pending
// slot that keeps a redirect alive while fetch is stalled.
module pc_redirect_unit
    import riscv_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                IMM_W       = 64,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_redirect_unit_if.slave     bus
);

    logic [STATE_W-1:0] state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pending_q;
    logic               flush_q;
    logic               taken_q;
    logic               misaligned_q;

    logic [ADDR_W-1:0]  imm_lo;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  sum;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_next_seq;
    logic               cond;
    logic               redirect_req;
    logic               redirect_ok;
    logic               unused_imm_hi;

    branch_cond_eval u_cond (
        .funct3    (bus.ex_funct3),
        .zero_flag (bus.zero_flag),
        .lt_flag   (bus.lt_flag),
        .ltu_flag  (bus.ltu_flag),
        .cond      (cond)
    );

    // Only the low ADDR_W bits of the immediate matter; addresses wrap silently.
    assign imm_lo        = bus.ex_imm[ADDR_W-1:0];
    assign unused_imm_hi = ^bus.ex_imm[IMM_W-1:ADDR_W];

    // JALR has top priority and is the only case that uses rs1 as the base.
    assign base   = bus.ex_jalr ? bus.ex_rs1 : bus.ex_pc;
    assign sum    = base + imm_lo;
    assign target = bus.ex_jalr ? {sum[ADDR_W-1:1], 1'b0} : sum;

    assign redirect_req = bus.ex_valid &
                          (bus.ex_jalr | bus.ex_jal | (bus.ex_branch & cond));
    // A target with bit 1 set is not a legal instruction address; drop it.
    assign redirect_ok  = redirect_req & !target[1];

    assign pc_next_seq  = pc_q + ADDR_W'(INSTR_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            // NOTE: the pending slot is reset too, so a redirect caught by reset can never resurface.
            pending_q    <= '0;
            flush_q      <= 1'b0;
            taken_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            flush_q      <= 1'b0;
            taken_q      <= 1'b0;
            misaligned_q <= redirect_req & target[1];
            case (state_q)
                ST_RUN: begin
                    if (redirect_ok) begin
                        if (bus.fetch_ready) begin
                            pc_q    <= target;
                            flush_q <= 1'b1;
                            taken_q <= 1'b1;
                        end else begin
                            pending_q <= target;
                            state_q   <= ST_HOLD;
                        end
                    end else if (bus.fetch_ready) begin
                        pc_q <= pc_next_seq;
                    end
                end
                ST_HOLD: begin
                    if (bus.fetch_ready) begin
                        // A same-cycle redirect is younger than the pending one and wins.
                        pc_q    <= redirect_ok ? target : pending_q;
                        flush_q <= 1'b1;
                        taken_q <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (redirect_ok) begin
                        pending_q <= target;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_next_seq;
    assign bus.flush      = flush_q;
    assign bus.taken      = taken_q;
    assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed plus randomized bench for pc_redirect_unit against a behavioural fetch-PC model.
module tb_pc_redirect_unit;

    localparam int AW = 8;
    localparam int IW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_redirect_unit_if #(.ADDR_W(AW), .IMM_W(IW)) bus ();

    pc_redirect_unit #(
        .ADDR_W      (AW),
        .IMM_W       (IW),
        .RESET_PC    (8'h00),
        .INSTR_BYTES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: architectural PC, optional pending target, output pulses.
    int m_pc   = 0;
    bit m_hold = 1'b0;
    int m_pend = 0;
    bit m_flush = 1'b0;
    bit m_mis   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_cond(input logic [2:0] f3, input bit z, input bit lt, input bit ltu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            3'd7:    return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_hold = 1'b0; m_pend = 0; m_flush = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_edge();
        int  tgt;
        int  imm_mod;
        bit  req;
        bit  ok;
        imm_mod = int'(bus.ex_imm % 64'd256);
        req = bus.ex_valid && (bus.ex_jal || bus.ex_jalr ||
              (bus.ex_branch && model_cond(bus.ex_funct3, bus.zero_flag, bus.lt_flag, bus.ltu_flag)));
        if (bus.ex_jalr) tgt = ((int'(bus.ex_rs1) + imm_mod) % 256) / 2 * 2;
        else             tgt = (int'(bus.ex_pc) + imm_mod) % 256;
        m_mis   = req && ((tgt / 2) % 2 == 1);
        ok      = req && !m_mis;
        m_flush = 1'b0;
        if (!m_hold) begin
            if (ok && bus.fetch_ready) begin
                m_pc = tgt; m_flush = 1'b1;
            end else if (ok) begin
                m_pend = tgt; m_hold = 1'b1;
            end else if (bus.fetch_ready) begin
                m_pc = (m_pc + 4) % 256;
            end
        end else begin
            if (ok) m_pend = tgt;
            if (bus.fetch_ready) begin
                m_pc = m_pend; m_hold = 1'b0; m_flush = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},         32'(bus.pc),         32'(m_pc));
        check({tag, ".pc_plus4"},   32'(bus.pc_plus4),   32'((m_pc + 4) % 256));
        check({tag, ".flush"},      32'(bus.flush),      32'(m_flush));
        check({tag, ".taken"},      32'(bus.taken),      32'(m_flush));
        check({tag, ".misaligned"}, 32'(bus.misaligned), 32'(m_mis));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit rdy, input bit v, input bit br, input bit jal, input bit jalr,
                         input logic [2:0] f3, input bit z, input bit lt, input bit ltu,
                         input int epc, input logic [63:0] imm, input int rs1);
        bus.fetch_ready = rdy;
        bus.ex_valid    = v;
        bus.ex_branch   = br;
        bus.ex_jal      = jal;
        bus.ex_jalr     = jalr;
        bus.ex_funct3   = f3;
        bus.zero_flag   = z;
        bus.lt_flag     = lt;
        bus.ltu_flag    = ltu;
        bus.ex_pc       = AW'(epc);
        bus.ex_imm      = imm;
        bus.ex_rs1      = AW'(rs1);
    endtask

    task automatic idle(input bit rdy);
        drive(rdy, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 64'd0, 0);
    endtask

    initial begin
        idle(1'b1);
        #12;
        check("reset.pc", 32'(bus.pc), 32'h00);
        check("reset.pc_plus4", 32'(bus.pc_plus4), 32'h04);
        check("reset.flush", 32'(bus.flush), 32'd0);
        check("reset.taken", 32'(bus.taken), 32'd0);
        check("reset.misaligned", 32'(bus.misaligned), 32'd0);
        rst_n = 1'b1;

        // Sequential fetch from reset up to 0x20.
        cycle("seq1"); check("seq1.lit", 32'(bus.pc), 32'h04);
        cycle("seq2"); check("seq2.lit", 32'(bus.pc), 32'h08);
        cycle("seq3"); check("seq3.lit", 32'(bus.pc), 32'h0C);
        for (int i = 0; i < 5; i++) cycle("seq");
        check("seq.at20", 32'(bus.pc), 32'h20);

        // BEQ taken and not taken.
        drive(1, 1, 1, 0, 0, 3'b000, 1, 0, 0, 'h20, 64'd4, 0);
        cycle("beq_t"); check("beq_t.pc", 32'(bus.pc), 32'h24);
        check("beq_t.flush", 32'(bus.flush), 32'd1);
        idle(1);
        cycle("after_beq"); check("after_beq.flush", 32'(bus.flush), 32'd0);
        drive(1, 1, 1, 0, 0, 3'b000, 0, 0, 0, 'h28, 64'd4, 0);
        cycle("beq_nt"); check("beq_nt.pc", 32'(bus.pc), 32'h2C);

        // BLT taken, BGEU not taken, funct3=010 never taken.
        drive(1, 1, 1, 0, 0, 3'b100, 0, 1, 0, 'h2C, 64'h14, 0);
        cycle("blt"); check("blt.pc", 32'(bus.pc), 32'h40);
        check("blt.taken", 32'(bus.taken), 32'd1);
        drive(1, 1, 1, 0, 0, 3'b111, 0, 0, 1, 'h40, 64'h10, 0);
        cycle("bgeu"); check("bgeu.taken", 32'(bus.taken), 32'd0);
        drive(1, 1, 1, 0, 0, 3'b010, 1, 1, 1, 'h44, 64'h10, 0);
        cycle("f3_010"); check("f3_010.pc", 32'(bus.pc), 32'h48);

        // JALR clears bit 0, JAL wraps, negative immediate, misaligned target.
        drive(1, 1, 0, 0, 1, 3'b000, 0, 0, 0, 'h00, 64'h3, 'h41);
        cycle("jalr"); check("jalr.pc", 32'(bus.pc), 32'h44);
        drive(1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 'hFC, 64'h8, 0);
        cycle("jal_wrap"); check("jal_wrap.pc", 32'(bus.pc), 32'h04);
        drive(1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 'h20, 64'h2, 0);
        cycle("misal"); check("misal.pc", 32'(bus.pc), 32'h08);
        check("misal.pulse", 32'(bus.misaligned), 32'd1);
        check("misal.flush", 32'(bus.flush), 32'd0);
        idle(1);
        cycle("misal_end");
        drive(1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 'h0C, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        cycle("jal_neg"); check("jal_neg.pc", 32'(bus.pc), 32'h04);

        // Redirect while stalled: held, then released.
        drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 'h30, 64'h10, 0);
        cycle("hold0"); check("hold0.flush", 32'(bus.flush), 32'd0);
        idle(0);
        cycle("hold1");
        cycle("hold2"); check("hold2.pc", 32'(bus.pc), 32'h04);
        idle(1);
        cycle("release"); check("release.pc", 32'(bus.pc), 32'h40);
        check("release.flush", 32'(bus.flush), 32'd1);
        cycle("release_end"); check("release_end.flush", 32'(bus.flush), 32'd0);

        // Second redirect during hold overwrites pending.
        drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 'h30, 64'h10, 0);
        cycle("ow0");
        drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 'h50, 64'h10, 0);
        cycle("ow1");
        idle(1);
        cycle("ow_rel"); check("ow_rel.pc", 32'(bus.pc), 32'h60);

        // Same-cycle redirect beats the pending target on release.
        drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 'h30, 64'h10, 0);
        cycle("sc0");
        drive(1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 'h70, 64'h10, 0);
        cycle("sc_rel"); check("sc_rel.pc", 32'(bus.pc), 32'h80);

        // Asynchronous reset while holding discards the pending redirect.
        drive(0, 1, 1, 0, 0, 3'b000, 1, 0, 0, 'h30, 64'h10, 0);
        cycle("rh0");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.pc", 32'(bus.pc), 32'h00);
        check("async_rst.flush", 32'(bus.flush), 32'd0);
        idle(1);
        #2;
        rst_n = 1'b1;
        cycle("post_rst"); check("post_rst.pc", 32'(bus.pc), 32'h04);
        check("post_rst.flush", 32'(bus.flush), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                  bit'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  {$urandom, $urandom}, int'($urandom_range(0, 255)));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
